// File: rtl/pe_filter_unpack.sv
// PE-side filter packet consumer: checks dest, latches the payload row, streams it one weight per beat.
// Optional build macro PE_FILTER_HOP_CHECK_EN: also require x/y hop fields to be zero before accepting.
module pe_filter_unpack #(
    parameter logic [3:0] NODE_ID      = 4'd1,
    parameter int         DEPTH_F      = 5,
    parameter int         WIDTH_data   = 8,
    parameter int         WIDTH_packet = 57,
    parameter int         REPLAY       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_packet-1:0] pkt_in,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    output logic [WIDTH_data-1:0]   w_data,
    output logic [2:0]              w_idx,
    output logic                    w_last,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [3:0]              src_id,
    output logic                    row_loaded,
    output logic                    drop_pulse
);

    localparam int ROW_W = DEPTH_F * WIDTH_data;
    localparam int IDX_W = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
    localparam int REP_W = (REPLAY > 1) ? $clog2(REPLAY) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH_F - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPLAY - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]            r_state;
    logic [ROW_W-1:0]      r_row;
    logic [IDX_W-1:0]      r_idx;
    logic [REP_W-1:0]      r_rep;
    logic [3:0]            r_src;
    logic                  r_loaded;
    logic                  r_drop;

    logic                  w_emit;
    logic                  w_idx_last;
    logic                  w_final;
    logic                  w_dest_ok;
    logic                  w_accept;
    logic                  w_unused_fields;
    logic [WIDTH_data-1:0] w_sel;

    assign w_emit     = (r_state == S_EMIT);
    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_final    = w_emit && w_idx_last && (r_rep == REP_LAST);
    assign w_dest_ok  = (pkt_in[51:48] == NODE_ID);

`ifdef PE_FILTER_HOP_CHECK_EN
    // Only packets that have finished routing (both hop counts exhausted) are taken.
    assign w_accept = w_dest_ok && (pkt_in[46:44] == 3'd0) && (pkt_in[42:40] == 3'd0);
`else
    assign w_accept = w_dest_ok;
`endif

    assign w_unused_fields = &{pkt_in[WIDTH_packet-1:56], pkt_in[47:40]};

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < DEPTH_F; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel = r_row[k*WIDTH_data +: WIDTH_data];
            end
        end
    end

    assign pkt_ready  = (r_state == S_IDLE);
    assign w_valid    = w_emit;
    assign w_data     = w_emit ? w_sel : '0;
    assign w_idx      = 3'(r_idx);
    assign w_last     = w_final;
    assign src_id     = r_src;
    assign row_loaded = r_loaded;
    assign drop_pulse = r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_idx    <= '0;
            r_rep    <= '0;
            r_src    <= 4'd0;
            r_loaded <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pkt_valid) begin
                        if (w_accept) begin
                            r_row    <= pkt_in[ROW_W-1:0];
                            r_src    <= pkt_in[55:52];
                            r_idx    <= '0;
                            r_rep    <= '0;
                            r_loaded <= 1'b1;
                            r_state  <= S_EMIT;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // Counters freeze while the MAC stalls, holding data/idx/last stable.
                    if (w_ready) begin
                        if (w_final) begin
                            r_state <= S_IDLE;
                        end else if (w_idx_last) begin
                            r_idx <= '0;
                            r_rep <= r_rep + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_filter_unpack.sv
// Bench for pe_filter_unpack: a REPLAY=1 and a REPLAY=3 instance, each tracked by a beat-queue model.
// Handshake: a weight moves on a rising edge where w_valid && w_ready; a packet moves where pkt_valid && pkt_ready.
module tb_pe_filter_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [56:0] pkt_in = '0;
    logic        pkt_valid1 = 1'b0;
    logic        pkt_valid3 = 1'b0;
    logic        w_ready1 = 1'b1;
    logic        w_ready3 = 1'b1;

    logic        pkt_ready1, w_last1, w_valid1, loaded1, drop1;
    logic [7:0]  w_data1;
    logic [2:0]  w_idx1;
    logic [3:0]  src1;
    logic        pkt_ready3, w_last3, w_valid3, loaded3, drop3;
    logic [7:0]  w_data3;
    logic [2:0]  w_idx3;
    logic [3:0]  src3;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_filter_unpack #(.NODE_ID(4'd1), .REPLAY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pkt_in(pkt_in), .pkt_valid(pkt_valid1),
        .pkt_ready(pkt_ready1), .w_data(w_data1), .w_idx(w_idx1), .w_last(w_last1),
        .w_valid(w_valid1), .w_ready(w_ready1), .src_id(src1),
        .row_loaded(loaded1), .drop_pulse(drop1)
    );

    pe_filter_unpack #(.NODE_ID(4'd1), .REPLAY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .pkt_in(pkt_in), .pkt_valid(pkt_valid3),
        .pkt_ready(pkt_ready3), .w_data(w_data3), .w_idx(w_idx3), .w_last(w_last3),
        .w_valid(w_valid3), .w_ready(w_ready3), .src_id(src3),
        .row_loaded(loaded3), .drop_pulse(drop3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [56:0] mk_pkt(input logic [3:0] src, input logic [3:0] dest,
                                           input logic [2:0] xh, input logic [2:0] yh,
                                           input logic [39:0] pl);
        return {1'b0, src, dest, 1'b0, xh, 1'b0, yh, pl};
    endfunction

    function automatic logic pkt_good(input logic [56:0] p);
`ifdef PE_FILTER_HOP_CHECK_EN
        return (p[51:48] == 4'd1) && (p[46:44] == 3'd0) && (p[42:40] == 3'd0);
`else
        return (p[51:48] == 4'd1);
`endif
    endfunction

    // ---------------- model: each entry is {last, idx[2:0], data[7:0]} ----------------
    logic [11:0] exp1_q[$];
    logic [11:0] exp3_q[$];
    logic [3:0]  m1_src, m3_src;
    logic        m1_loaded, m3_loaded, m1_drop, m3_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp1_q.delete();
            m1_src <= 4'd0; m1_loaded <= 1'b0; m1_drop <= 1'b0;
        end else begin
            m1_drop <= 1'b0;
            if (exp1_q.size() > 0) begin
                if (w_ready1) void'(exp1_q.pop_front());
            end else if (pkt_valid1) begin
                if (pkt_good(pkt_in)) begin
                    for (int k = 0; k < 5; k++)
                        exp1_q.push_back({(k == 4), 3'(k), 8'(pkt_in[39:0] >> (8*k))});
                    m1_src <= pkt_in[55:52]; m1_loaded <= 1'b1;
                end else begin
                    m1_drop <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp3_q.delete();
            m3_src <= 4'd0; m3_loaded <= 1'b0; m3_drop <= 1'b0;
        end else begin
            m3_drop <= 1'b0;
            if (exp3_q.size() > 0) begin
                if (w_ready3) void'(exp3_q.pop_front());
            end else if (pkt_valid3) begin
                if (pkt_good(pkt_in)) begin
                    for (int r = 0; r < 3; r++)
                        for (int k = 0; k < 5; k++)
                            exp3_q.push_back({(r == 2 && k == 4), 3'(k), 8'(pkt_in[39:0] >> (8*k))});
                    m3_src <= pkt_in[55:52]; m3_loaded <= 1'b1;
                end else begin
                    m3_drop <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic v1, v3, l1, l3;
        v1 = (exp1_q.size() > 0);
        v3 = (exp3_q.size() > 0);
        l1 = v1 ? exp1_q[0][11] : 1'b0;
        l3 = v3 ? exp3_q[0][11] : 1'b0;
        check("model1_ctrl", {w_valid1, pkt_ready1, src1, loaded1, drop1, w_last1},
                             {v1, !v1, m1_src, m1_loaded, m1_drop, l1});
        if (v1) check("model1_beat", {w_idx1, w_data1}, exp1_q[0][10:0]);
        check("model3_ctrl", {w_valid3, pkt_ready3, src3, loaded3, drop3, w_last3},
                             {v3, !v3, m3_src, m3_loaded, m3_drop, l3});
        if (v3) check("model3_beat", {w_idx3, w_data3}, exp3_q[0][10:0]);
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [56:0] p);
        pkt_in = p; pkt_valid1 = 1'b1;
        tick();
        pkt_valid1 = 1'b0;
    endtask

    task automatic drain1();
        for (int i = 0; i < 40; i++) begin
            if (pkt_ready1) break;
            tick();
        end
        check("drain1_timeout", pkt_ready1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        logic [3:0] pat;
        int last_pos;

        #1;
        check("reset_vals1", {pkt_ready1, w_valid1, w_data1, w_idx1, w_last1, src1, loaded1, drop1},
                             {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0});
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic row: source 11, payload 05..01
        send1(mk_pkt(4'd11, 4'd1, 3'd0, 3'd0, 40'h0504030201));
        check("first_beat", {w_valid1, pkt_ready1, w_idx1, w_data1, w_last1}, {1'b1, 1'b0, 3'd0, 8'h01, 1'b0});
        for (int k = 1; k < 5; k++) begin
            tick();
            check("stream_beat", {w_idx1, w_data1}, {3'(k), 8'(k + 1)});
        end
        check("last_beat", {w_last1, src1, loaded1}, {1'b1, 4'd11, 1'b1});
        tick();
        check("ready_back", {pkt_ready1, w_valid1}, {1'b1, 1'b0});

        // wrong destination
        send1(mk_pkt(4'd6, 4'd3, 3'd0, 3'd0, 40'hDEADBEEF00));
        check("drop_hi", {drop1, w_valid1, loaded1, src1}, {1'b1, 1'b0, 1'b1, 4'd11});
        tick();
        check("drop_lo", drop1, 1'b0);

        // backpressure 1,0,0,1 repeating
        send1(mk_pkt(4'd2, 4'd1, 3'd0, 3'd0, 40'h0504030201));
        pat = 4'b1001;
        got.delete();
        for (int i = 0; i < 40 && got.size() < 5; i++) begin
            w_ready1 = pat[i % 4];
            if (w_valid1 && w_ready1) got.push_back(w_data1);
            tick();
        end
        w_ready1 = 1'b1;
        check("bp_count", got.size(), 5);
        for (int k = 0; k < got.size(); k++) check("bp_seq", got[k], 8'(k + 1));
        drain1();

        // replay three times on the second instance
        pkt_in = mk_pkt(4'd9, 4'd1, 3'd0, 3'd0, 40'h0504030201);
        pkt_valid3 = 1'b1;
        tick();
        pkt_valid3 = 1'b0;
        got.delete();
        last_pos = 0;
        for (int i = 0; i < 30 && last_pos == 0; i++) begin
            if (w_valid3 && w_ready3) begin
                got.push_back(w_data3);
                if (w_last3) last_pos = got.size();
            end
            tick();
        end
        check("replay_count", got.size(), 15);
        check("replay_last_pos", last_pos, 15);
        for (int k = 0; k < got.size(); k++) check("replay_seq", got[k], 8'((k % 5) + 1));
        check("replay_idle", {pkt_ready3, w_valid3, src3}, {1'b1, 1'b0, 4'd9});

        // asynchronous reset mid-row
        send1(mk_pkt(4'd4, 4'd1, 3'd0, 3'd0, 40'h0504030201));
        tick();
        check("pre_reset_byte", w_data1, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {w_valid1, pkt_ready1, loaded1, src1, w_data1, w_last1},
                             {1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0});
        tick();
        #2 rst_n = 1'b1;
        tick();
        send1(mk_pkt(4'd5, 4'd1, 3'd0, 3'd0, 40'hAABBCCDDEE));
        check("after_reset_first", {w_valid1, w_idx1, w_data1, src1}, {1'b1, 3'd0, 8'hEE, 4'd5});
        drain1();

        // hop fields
        send1(mk_pkt(4'd7, 4'd1, 3'd0, 3'd1, 40'h1122334455));
`ifdef PE_FILTER_HOP_CHECK_EN
        check("hop_drop", {drop1, w_valid1}, {1'b1, 1'b0});
`else
        check("hop_ignored", {w_valid1, w_data1, drop1}, {1'b1, 8'h55, 1'b0});
`endif
        drain1();
        tick();
        send1(mk_pkt(4'd7, 4'd1, 3'd0, 3'd0, 40'h1122334455));
        check("hop_zero_accept", {w_valid1, w_data1, src1}, {1'b1, 8'h55, 4'd7});
        drain1();
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
